cmd_issuer: RTL

CMD_ISSUER -- requirements
Module: cmd_issuer

---
 rtl/cmd_issuer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cmd_issuer.sv
// cmd_issuer: buffers host commands in a FIFO and issues them one at a time to a core,
// waiting for completion, capturing ALU flags and flagging lost completions.
`default_nettype none

module cmd_issuer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_valid,
  input  logic [11:0] push_cmd,
  output logic        push_ready,
  input  logic        run,
  input  logic        clr_err,
  output logic        start_cmd,
  output logic [2:0]  op_out,
  output logic [2:0]  rd_out,
  output logic [2:0]  rs1_out,
  output logic [2:0]  rs2_out,
  input  logic        cmd_done,
  input  logic        z_flag_in,
  input  logic        c_flag_in,
  output logic        last_z,
  output logic        last_c,
  output logic        busy,
  output logic [3:0]  fifo_count,
  output logic [7:0]  exec_count,
  output logic        timeout_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [4:0]    DEPTH_C   = 5'(DEPTH);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t          state;
  logic [11:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [TW-1:0]   timer;
  logic            push_fire;
  logic            pop_fire;

  // Full blocks pushes even when a pop happens in the same cycle.
  assign push_ready = ({1'b0, fifo_count} < DEPTH_C);
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = (state == S_ISSUE);

  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem[wr_ptr] <= push_cmd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= 4'd0;
    end else begin
      if (push_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_fire, pop_fire})
        2'b10:   fifo_count <= fifo_count + 4'd1;
        2'b01:   fifo_count <= fifo_count - 4'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      start_cmd   <= 1'b0;
      op_out      <= 3'd0;
      rd_out      <= 3'd0;
      rs1_out     <= 3'd0;
      rs2_out     <= 3'd0;
      last_z      <= 1'b0;
      last_c      <= 1'b0;
      busy        <= 1'b0;
      exec_count  <= 8'd0;
      timeout_err <= 1'b0;
      timer       <= '0;
    end else begin
      start_cmd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run && (fifo_count != 4'd0) && !timeout_err) begin
            state     <= S_ISSUE;
            {op_out, rd_out, rs1_out, rs2_out} <= mem[rd_ptr];
            start_cmd <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
          timer <= '0;
        end
        S_WAIT: begin
          if (cmd_done) begin
            last_z     <= z_flag_in;
            last_c     <= c_flag_in;
            exec_count <= exec_count + 8'd1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else if (timer == TIMER_MAX) begin
            // Completion considered lost; the command is dropped, not retried.
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= S_ERR;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_ERR: begin
          if (clr_err) begin
            timeout_err <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
